// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared definitions for the fp16 sequencer and its arithmetic unit.
//            Provides op encodings, FSM state type, fp16 constants and the
//            common round-to-nearest-even packing helper.
// Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam logic [1:0]  OP_ADD    = 2'b00;
    localparam logic [1:0]  OP_MUL    = 2'b01;
    localparam logic [1:0]  OP_MAC    = 2'b10;
    localparam logic [1:0]  OP_ACC    = 2'b11;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // n[13] is the hidden bit, n[12:3] the fraction, n[2] guard, n[1:0]
    // round/sticky. A clear hidden bit means the value is exactly zero.
    // Underflow flushes to signed zero, overflow saturates to infinity.
    function automatic logic [15:0] fp_round_pack(input logic              s,
                                                  input logic signed [7:0] e,
                                                  input logic [13:0]       n);
        logic              up;
        logic [10:0]       m;
        logic signed [7:0] er;
        up = n[2] & (n[3] | n[1] | n[0]);
        m  = {1'b0, n[12:3]} + {10'b0, up};
        // fraction carry-out means the mantissa became 2.0 -> bump exponent
        er = e + (m[10] ? 8'sd1 : 8'sd0);
        if (!n[13] || er <= 8'sd0)
            return {s, 15'h0000};
        else if (er >= 8'sd31)
            return {s, 5'h1F, 10'h000};
        else
            return {s, er[4:0], m[9:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16.sv
`default_nettype none
// ============================================================================
// Module   : fp16
// Purpose  : Combinational IEEE half-precision add / multiply unit with
//            round-to-nearest-even. Subnormal inputs and results are flushed
//            to zero; NaN/infinity are handled.
// Ports    : a, b        fp16 operands
//            ALUControl  MUL_CTRL selects multiply, anything else selects add
//            Result      fp16 result
// Revision : 1.0  initial release
// ============================================================================
module fp16
    import fp_pkg::*;
#(
    parameter logic MUL_CTRL = 1'b1
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ALUControl,
    output logic [15:0] Result
);

    logic        w_sa, w_sb;
    logic [4:0]  w_ea, w_eb;
    logic [9:0]  w_fa, w_fb;
    assign {w_sa, w_ea, w_fa} = a;
    assign {w_sb, w_eb, w_fb} = b;

    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    assign w_a_zero = (w_ea == 5'd0);
    assign w_b_zero = (w_eb == 5'd0);
    assign w_a_inf  = (w_ea == 5'h1F) && (w_fa == 10'd0);
    assign w_b_inf  = (w_eb == 5'h1F) && (w_fb == 10'd0);
    assign w_a_nan  = (w_ea == 5'h1F) && (w_fa != 10'd0);
    assign w_b_nan  = (w_eb == 5'h1F) && (w_fb != 10'd0);

    // ---------------- multiply path ----------------
    logic [21:0]       w_prod, w_pnorm;
    logic signed [7:0] w_pexp;
    logic [15:0]       w_mul_norm;
    assign w_prod  = {1'b1, w_fa} * {1'b1, w_fb};
    assign w_pnorm = w_prod[21] ? w_prod : {w_prod[20:0], 1'b0};
    assign w_pexp  = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 8'sd15
                   + (w_prod[21] ? 8'sd1 : 8'sd0);
    assign w_mul_norm = fp_round_pack(w_sa ^ w_sb, w_pexp,
                                      {w_pnorm[21:9], |w_pnorm[8:0]});

    // ---------------- add path ----------------
    logic              w_swap, w_sl, w_sub;
    logic [4:0]        w_el, w_es, w_d;
    logic [10:0]       w_ml, w_ms;
    logic [31:0]       w_sh;
    logic [13:0]       w_al, w_an;
    logic [14:0]       w_sum;
    logic [3:0]        w_lz;
    logic signed [7:0] w_aexp;
    logic [15:0]       w_add_norm;

    assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_el   = w_swap ? w_eb : w_ea;
    assign w_es   = w_swap ? w_ea : w_eb;
    assign w_ml   = {1'b1, (w_swap ? w_fb : w_fa)};
    assign w_ms   = {1'b1, (w_swap ? w_fa : w_fb)};
    assign w_sl   = w_swap ? w_sb : w_sa;
    assign w_sub  = w_sa ^ w_sb;
    assign w_d    = w_el - w_es;

    // 32-bit window keeps at least the top bit for any 5-bit shift, so the
    // sticky bit is never lost.
    assign w_sh  = {w_ms, 21'b0} >> w_d;
    assign w_al  = {w_sh[31:19], w_sh[18] | (|w_sh[17:0])};
    assign w_sum = w_sub ? ({1'b0, w_ml, 3'b000} - {1'b0, w_al})
                         : ({1'b0, w_ml, 3'b000} + {1'b0, w_al});

    always_comb begin
        w_lz = 4'd14;
        for (int i = 0; i <= 13; i++) begin
            if (w_sum[i]) w_lz = 4'(13 - i);
        end
    end

    always_comb begin
        if (w_sum[14]) begin
            w_an   = {w_sum[14:2], w_sum[1] | w_sum[0]};
            w_aexp = $signed({3'b000, w_el}) + 8'sd1;
        end else begin
            w_an   = w_sum[13:0] << w_lz;
            w_aexp = $signed({3'b000, w_el}) - $signed({4'b0000, w_lz});
        end
    end

    // exact cancellation yields +0
    assign w_add_norm = fp_round_pack((w_sum == 15'd0) ? 1'b0 : w_sl, w_aexp, w_an);

    // ---------------- special-value selection ----------------
    always_comb begin
        Result = FP16_ZERO;
        if (ALUControl == MUL_CTRL) begin
            if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
                Result = FP16_QNAN;
            else if (w_a_inf || w_b_inf)
                Result = {w_sa ^ w_sb, 5'h1F, 10'h000};
            else if (w_a_zero || w_b_zero)
                Result = {w_sa ^ w_sb, 15'h0000};
            else
                Result = w_mul_norm;
        end else begin
            if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_sub))
                Result = FP16_QNAN;
            else if (w_a_inf)
                Result = a;
            else if (w_b_inf)
                Result = b;
            else if (w_a_zero)
                Result = w_b_zero ? {w_sa & w_sb, 15'h0000} : b;
            else if (w_b_zero)
                Result = a;
            else
                Result = w_add_norm;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp16_seq_ctrl
// Purpose  : Multicycle sequencer time-sharing one fp16 add/mul unit to run
//            ADD, MUL, MAC (a*b+c) and ACC (acc += a*b).
// Ports    : clk        rising-edge clock
//            reset      asynchronous active-low reset
//            start/op   request and opcode, accepted in IDLE or DONE
//            a, b, c    fp16 operands (c used by MAC only)
//            clear_acc  accumulator clear, honoured while not busy
//            busy       high in EXEC1/EXEC2
//            done       one-cycle completion pulse
//            result     last completed result
//            acc_out    accumulator value
// Revision : 1.0  initial release
// ============================================================================
module fp16_seq_ctrl
    import fp_pkg::*;
#(
    parameter logic ADD_CTRL = 1'b0,
    parameter logic MUL_CTRL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic        clear_acc,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] acc_out
);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [15:0] r_a, r_b, r_c, r_tmp, r_acc, r_result;
    logic        r_busy, r_done;

    logic [15:0] w_fp_a, w_fp_b, w_fp_res;
    logic        w_fp_ctrl;

    // Operand steering; the unit sees zeros when idle to avoid needless toggling.
    always_comb begin
        w_fp_a    = FP16_ZERO;
        w_fp_b    = FP16_ZERO;
        w_fp_ctrl = ADD_CTRL;
        case (r_state)
            ST_EXEC1: begin
                w_fp_a    = r_a;
                w_fp_b    = r_b;
                w_fp_ctrl = (r_op == OP_ADD) ? ADD_CTRL : MUL_CTRL;
            end
            ST_EXEC2: begin
                w_fp_a    = r_tmp;
                w_fp_b    = (r_op == OP_MAC) ? r_c : r_acc;
                w_fp_ctrl = ADD_CTRL;
            end
            default: ;
        endcase
    end

    fp16 #(
        .MUL_CTRL   (MUL_CTRL)
    ) u_fp16 (
        .a          (w_fp_a),
        .b          (w_fp_b),
        .ALUControl (w_fp_ctrl),
        .Result     (w_fp_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_a      <= FP16_ZERO;
            r_b      <= FP16_ZERO;
            r_c      <= FP16_ZERO;
            r_tmp    <= FP16_ZERO;
            r_acc    <= FP16_ZERO;
            r_result <= FP16_ZERO;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    // EXEC2 of an ACC accepted on this edge reads the cleared value
                    if (clear_acc) r_acc <= FP16_ZERO;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= c;
                        r_op    <= op;
                        r_state <= ST_EXEC1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC1: begin
                    if (r_op == OP_ADD || r_op == OP_MUL) begin
                        r_result <= w_fp_res;
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_tmp    <= w_fp_res;
                        r_state  <= ST_EXEC2;
                    end
                end
                ST_EXEC2: begin
                    r_result <= w_fp_res;
                    if (r_op == OP_ACC) r_acc <= w_fp_res;
                    r_state  <= ST_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign acc_out = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fp16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_seq_ctrl
// Purpose  : Self-checking bench for fp16_seq_ctrl with a real-arithmetic
//            fp16 reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp16_seq_ctrl;

    localparam logic [1:0] T_ADD = 2'b00;
    localparam logic [1:0] T_MUL = 2'b01;
    localparam logic [1:0] T_MAC = 2'b10;
    localparam logic [1:0] T_ACC = 2'b11;

    logic        clk = 1'b0;
    logic        reset, start, clear_acc;
    logic [1:0]  op;
    logic [15:0] a, b, c;
    logic        busy, done;
    logic [15:0] result, acc_out;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_acc    = 16'h0000;

    fp16_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .clear_acc (clear_acc),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic real f2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = real'(1024 + int'(h[9:0]));
        e = int'(h[14:10]) - 25;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2f(input real x);
        real  m, fr;
        int   e, n;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        m  = m * 1024.0;
        n  = $rtoi(m);
        fr = m - real'(n);
        if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
        if (n == 2048) begin n = 1024; e++; end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0)  return {s, 15'h0000};
        return {s, 5'(e), 10'(n - 1024)};
    endfunction

    function automatic logic [15:0] ref_op(input logic [1:0] o,
                                           input logic [15:0] x, y, z);
        logic [15:0] p;
        case (o)
            T_ADD: return r2f(f2r(x) + f2r(y));
            T_MUL: return r2f(f2r(x) * f2r(y));
            T_MAC: begin
                p = r2f(f2r(x) * f2r(y));
                return r2f(f2r(p) + f2r(z));
            end
            default: begin
                p     = r2f(f2r(x) * f2r(y));
                m_acc = r2f(f2r(p) + f2r(m_acc));
                return m_acc;
            end
        endcase
    endfunction

    function automatic logic [15:0] rnd_fp(input bit pos);
        logic s;
        s = pos ? 1'b0 : 1'($urandom_range(0, 1));
        return {s, 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))};
    endfunction

    // Issue one op (called just after a rising edge); returns when done seen.
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, y, z,
                         output logic [15:0] res, output int lat, output int nb);
        op = o; a = x; b = y; c = z; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 16'h0; b = 16'h0; c = 16'h0;
        lat = 1;
        nb  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) nb++;
        end
        if (done !== 1'b1) lat = -1;
        res = result;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; start = 1'b0; clear_acc = 1'b0;
        op = 2'b00; a = 16'h0; b = 16'h0; c = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (result !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", result); else n_pass++;
        n_checks++; if (acc_out !== 16'h0000) $display("FAIL reset_acc: got %h expected 0000", acc_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_ops();
        logic [15:0] res;
        int lat, nb;
        do_op(T_ADD, 16'h3C00, 16'h4000, 16'h0, res, lat, nb);
        n_checks++; if (res !== 16'h4200) $display("FAIL add_result: got %h expected 4200", res); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL add_latency: got %0d expected 2", lat); else n_pass++;
        n_checks++; if (nb !== 1) $display("FAIL add_busy_cycles: got %0d expected 1", nb); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL add_done_single: got %b expected 0", done); else n_pass++;

        do_op(T_MUL, 16'h4000, 16'h3E00, 16'h0, res, lat, nb);
        n_checks++; if (res !== 16'h4200) $display("FAIL mul_result: got %h expected 4200", res); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL mul_latency: got %0d expected 2", lat); else n_pass++;
        n_checks++; if (acc_out !== 16'h0000) $display("FAIL mul_acc_unchanged: got %h expected 0000", acc_out); else n_pass++;
        @(posedge clk); #1;

        do_op(T_MAC, 16'h4000, 16'h4200, 16'h3C00, res, lat, nb);
        n_checks++; if (res !== 16'h4700) $display("FAIL mac_result: got %h expected 4700", res); else n_pass++;
        n_checks++; if (lat !== 3) $display("FAIL mac_latency: got %0d expected 3", lat); else n_pass++;
        n_checks++; if (nb !== 2) $display("FAIL mac_busy_cycles: got %0d expected 2", nb); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_accumulate();
        logic [15:0] res;
        int lat, nb;
        clear_acc = 1'b1;
        @(posedge clk); #1;
        clear_acc = 1'b0;
        do_op(T_ACC, 16'h4000, 16'h3E00, 16'h0, res, lat, nb);
        n_checks++; if (acc_out !== 16'h4200) $display("FAIL acc1_value: got %h expected 4200", acc_out); else n_pass++;
        n_checks++; if (lat !== 3) $display("FAIL acc1_latency: got %0d expected 3", lat); else n_pass++;
        do_op(T_ACC, 16'h3C00, 16'h3C00, 16'h0, res, lat, nb);
        n_checks++; if (acc_out !== 16'h4400) $display("FAIL acc2_value: got %h expected 4400", acc_out); else n_pass++;
        n_checks++; if (res !== 16'h4400) $display("FAIL acc2_result: got %h expected 4400", res); else n_pass++;
        @(posedge clk); #1;

        // clear while busy is ignored
        op = T_ADD; a = 16'h3C00; b = 16'h3C00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear_acc = 1'b1;
        @(posedge clk); #1;
        clear_acc = 1'b0;
        n_checks++; if (acc_out !== 16'h4400) $display("FAIL clear_while_busy: got %h expected 4400", acc_out); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL clear_while_busy_done: got %b expected 1", done); else n_pass++;
        @(posedge clk); #1;

        // clear together with an accepted ACC: the ACC adds to zero
        clear_acc = 1'b1;
        do_op(T_ACC, 16'h3C00, 16'h4000, 16'h0, res, lat, nb);
        clear_acc = 1'b0;
        n_checks++; if (acc_out !== 16'h4000) $display("FAIL clear_with_acc: got %h expected 4000", acc_out); else n_pass++;
        m_acc = 16'h4000;
        @(posedge clk); #1;
    endtask

    task automatic test_handshake();
        logic [15:0] res;
        int lat, nb, ndone;
        // start with a different op while in EXEC1 must be ignored
        op = T_MUL; a = 16'h4000; b = 16'h3E00; start = 1'b1;
        @(posedge clk); #1;
        op = T_ADD; a = 16'h3C00; b = 16'h3C00;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = (done === 1'b1) ? 1 : 0;
        n_checks++; if (result !== 16'h4200) $display("FAIL ignore_start_result: got %h expected 4200", result); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 1) $display("FAIL ignore_start_done_count: got %0d expected 1", ndone); else n_pass++;

        // back-to-back starts issued from DONE
        do_op(T_ADD, 16'h3C00, 16'h3C00, 16'h0, res, lat, nb);
        n_checks++; if (res !== 16'h4000) $display("FAIL b2b_first: got %h expected 4000", res); else n_pass++;
        do_op(T_MUL, 16'h4000, 16'h4000, 16'h0, res, lat, nb);
        n_checks++; if (res !== 16'h4400) $display("FAIL b2b_second: got %h expected 4400", res); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL b2b_second_latency: got %0d expected 2", lat); else n_pass++;
        do_op(T_MAC, 16'h4000, 16'h4000, 16'h3C00, res, lat, nb);
        n_checks++; if (res !== 16'h4500) $display("FAIL b2b_third: got %h expected 4500", res); else n_pass++;
        n_checks++; if (lat !== 3) $display("FAIL b2b_third_latency: got %0d expected 3", lat); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] res, x, y, z, exp_res;
        logic [1:0]  o;
        int lat, nb;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                clear_acc = 1'b1;
                @(posedge clk); #1;
                clear_acc = 1'b0;
                m_acc = 16'h0000;
            end
            o = 2'($urandom_range(0, 3));
            x = rnd_fp(o[1]);
            y = rnd_fp(o[1]);
            z = rnd_fp(1'b1);
            exp_res = ref_op(o, x, y, z);
            do_op(o, x, y, z, res, lat, nb);
            n_checks++; if (res !== exp_res) $display("FAIL rand_result[%0d] op=%0d a=%h b=%h c=%h: got %h expected %h", i, o, x, y, z, res, exp_res); else n_pass++;
            n_checks++; if (acc_out !== m_acc) $display("FAIL rand_acc[%0d]: got %h expected %h", i, acc_out, m_acc); else n_pass++;
            n_checks++; if (lat !== (o[1] ? 3 : 2)) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, (o[1] ? 3 : 2)); else n_pass++;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        logic [15:0] res;
        int lat, nb, ndone;
        do_op(T_ACC, 16'h3C00, 16'h3C00, 16'h0, res, lat, nb);
        @(posedge clk); #1;
        op = T_MAC; a = 16'h4000; b = 16'h4200; c = 16'h3C00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL midop_in_exec2: got busy %b expected 1", busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (result !== 16'h0000) $display("FAIL midop_result: got %h expected 0000", result); else n_pass++;
        n_checks++; if (acc_out !== 16'h0000) $display("FAIL midop_acc: got %h expected 0000", acc_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midop_busy: got %b expected 0", busy); else n_pass++;
        ndone = (done === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) $display("FAIL midop_no_done: got %0d pulses expected 0", ndone); else n_pass++;
        do_op(T_ADD, 16'h3C00, 16'h3C00, 16'h0, res, lat, nb);
        n_checks++; if (res !== 16'h4000) $display("FAIL post_reset_add: got %h expected 4000", res); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL post_reset_latency: got %0d expected 2", lat); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_accumulate();
        test_handshake();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fp16_seq_ctrl.md
Name: fp16_seq_ctrl

Overview:
Multicycle sequencer that owns one instance of the existing combinational fp16 add/mul unit and time-shares it to run ADD, MUL, MAC ((a*b)+c) and ACC (acc += a*b).
- Sits between the multicycle control unit and fp16, replacing a direct datapath connection.
- Start/busy/done handshake; registered result; internal 16-bit accumulator.

Parameters:
ADD_CTRL, 1'b0, ALUControl value that selects fp16 add
MUL_CTRL, 1'b1, ALUControl value that selects fp16 multiply

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; forces reset state immediately
start  input  1  request a new operation; sampled only when accepted (see Behaviour)
op  input  2  00 ADD a+b, 01 MUL a*b, 10 MAC a*b+c, 11 ACC acc+a*b
a  input  16  fp16 operand A
b  input  16  fp16 operand B
c  input  16  fp16 addend, used by MAC only
clear_acc  input  1  synchronous accumulator clear
busy  output  1  high in EXEC1/EXEC2
done  output  1  one-cycle pulse; result valid that cycle
result  output  16  registered result of last completed op; held until next completion
acc_out  output  16  current accumulator value

Behaviour:
- Reset (reset=0, async): state=IDLE; result=16'h0000; acc=16'h0000; done=0; busy=0; operand regs 0.
- FSM states: IDLE, EXEC1, EXEC2, DONE.
- Accept: start=1 in IDLE or DONE -> latch a,b,c,op into a_r,b_r,c_r,op_r; next state EXEC1.
- DONE without start -> IDLE. start in EXEC1/EXEC2 ignored, no side effects, never queued.
- EXEC1: fp16 a=a_r, b=b_r.
  - ALUControl=ADD_CTRL for op ADD, MUL_CTRL otherwise.
  - ADD/MUL: result<=fp16.Result, next DONE.
  - MAC/ACC: tmp<=fp16.Result, next EXEC2.
- EXEC2: fp16 a=tmp, b=(op_r==MAC ? c_r : acc), ALUControl=ADD_CTRL.
  - result<=fp16.Result; ACC also writes acc<=fp16.Result; next DONE.
- done=1 exactly in DONE state (registered, glitch-free); busy=(state==EXEC1 | state==EXEC2).
- Latency, accept edge to done cycle: ADD/MUL 2 cycles; MAC/ACC 3 cycles.
- Back-to-back start in DONE: next op completes with no idle bubble, giving 2- or 3-cycle throughput.
- clear_acc:
  - Honoured only when busy=0; acc<=0 on that edge. Ignored while busy.
  - clear_acc with an accepted ACC start on the same edge: clear applies, and the ACC adds to 0.
- Unused fp16 inputs in IDLE/DONE are driven to 0 (deterministic, lower toggle).
- Reset mid-operation (any state): abort immediately; no done pulse; acc and result cleared.
- fp16 results, including special values and rounding, are passed through unmodified. This block adds no arithmetic.

Decomposition:
- Shared package fp_pkg: op encodings (OP_ADD=2'b00, OP_MUL=2'b01, OP_MAC=2'b10, OP_ACC=2'b11), state encoding, FP16_ZERO=16'h0000.
- Sub-module: the existing fp16 unit, instantiated once. No other sub-modules; the FSM and registers stay in fp16_seq_ctrl.

Test Plan:
- ADD a=3C00,b=4000 -> done 2 cycles after accept; result=4200; busy high exactly 1 cycle.
- MUL a=4000,b=3E00 -> result=4200 at 2 cycles; acc_out unchanged (0000).
- MAC a=4000,b=4200,c=3C00 -> result=4700 at 3 cycles; busy high exactly 2 cycles.
- Accumulator sequence:
  - clear_acc, then ACC(4000,3E00) -> acc_out=4200.
  - ACC(3C00,3C00) -> acc_out=4400, result=4400.
  - clear_acc asserted while busy -> ignored, acc stays 4400.
- Handshake:
  - start pulsed in EXEC1 with op=ADD -> ignored, single done.
  - start held in DONE -> second op accepted, done pulses on consecutive op completions with no IDLE cycle.
- Reset mid-op: assert reset (0) during EXEC2 of MAC -> result=0000, acc_out=0000, busy=0, no done.
  - After release, ADD 3C00+3C00 -> 4000.
